// File: rtl/spi_ctrl_pkg.sv
// Shared SPI controller definitions: arbiter states, {CKP,CPH} mode
// encoding and default parameter values. Also used by the transmitter
// and receiver datapath.
package spi_ctrl_pkg;

    // Arbiter sequencing states
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SETUP = 3'd1,
        ST_XFER  = 3'd2,
        ST_HOLD  = 3'd3,
        ST_GAP   = 3'd4
    } state_e;

    // SPI mode as carried on the request ports: {CKP, CPH}
    typedef struct packed {
        logic ckp;
        logic cph;
    } spi_mode_t;

    localparam spi_mode_t SPI_MODE0 = '{ckp: 1'b0, cph: 1'b0};
    localparam spi_mode_t SPI_MODE1 = '{ckp: 1'b0, cph: 1'b1};
    localparam spi_mode_t SPI_MODE2 = '{ckp: 1'b1, cph: 1'b0};
    localparam spi_mode_t SPI_MODE3 = '{ckp: 1'b1, cph: 1'b1};

    // Default parameter values
    localparam int DEF_N_REQ       = 4;
    localparam int DEF_DATA_W      = 8;
    localparam int DEF_GUARD_CYC   = 2;
    localparam int DEF_TIMEOUT_CYC = 1023;

endpackage

// File: rtl/spi_rr_pick.sv
// Rotating-priority picker: the first requester at or after rr_ptr
// (ascending, wrapping) with req high wins.
module spi_rr_pick #(
    parameter int N_REQ = 4,
    parameter int PTR_W = 2
) (
    input  logic [N_REQ-1:0] req,
    input  logic [PTR_W-1:0] rr_ptr,
    output logic [PTR_W-1:0] grant_idx,
    output logic             grant_vld
);

    // Scan offsets from farthest to nearest so the nearest hit wins
    always_comb begin
        int slot;
        // NOTE: every output gets a default before the loop so no path leaves it unassigned (no latch).
        grant_vld = 1'b0;
        grant_idx = '0;
        slot      = 0;
        for (int k = N_REQ - 1; k >= 0; k--) begin
            slot = int'(rr_ptr) + k;
            if (slot >= N_REQ) begin
                slot = slot - N_REQ;
            end
            if (req[PTR_W'(slot)]) begin
                grant_vld = 1'b1;
                grant_idx = PTR_W'(slot);
            end
        end
    end

endmodule

// File: rtl/spi_master_arbiter.sv
// Round-robin scheduler sharing one SPI transmitter among N_REQ
// requesters: drives the granted slave select with setup/hold guard
// times, launches the transfer, supervises it with a timeout and returns
// the received byte with a one-cycle ack.
module spi_master_arbiter
    import spi_ctrl_pkg::*;
#(
    parameter int N_REQ       = DEF_N_REQ,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int GUARD_CYC   = DEF_GUARD_CYC,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req,
    input  logic [N_REQ*DATA_W-1:0]   req_data,
    input  logic [2*N_REQ-1:0]        req_mode,
    output logic [N_REQ-1:0]          ack,
    output logic [DATA_W-1:0]         rsp_data,
    output logic                      err,
    output logic                      busy,
    output logic [N_REQ-1:0]          ss_n,
    output logic                      tx_start,
    output logic [DATA_W-1:0]         tx_data,
    output logic                      tx_ckp,
    output logic                      tx_cph,
    output logic                      tx_abort,
    input  logic                      tx_done,
    input  logic [DATA_W-1:0]         tx_rx_data
);

    localparam int PTR_W = $clog2(N_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);

    // Counter compare points; one counter serves guard and timeout phases
    localparam logic [CNT_W-1:0] GUARD_LAST = CNT_W'(GUARD_CYC - 1);
    localparam logic [CNT_W-1:0] TO_WARN    = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(TIMEOUT_CYC);

    state_e              state_q,    state_d;
    logic [CNT_W-1:0]    cnt_q,      cnt_d;
    logic [PTR_W-1:0]    gnt_q,      gnt_d;
    logic [PTR_W-1:0]    rr_ptr_q,   rr_ptr_d;
    logic [DATA_W-1:0]   tx_data_q,  tx_data_d;
    spi_mode_t           mode_q,     mode_d;
    logic [DATA_W-1:0]   rsp_data_q, rsp_data_d;
    logic                err_pend_q, err_pend_d;
    logic                err_q,      err_d;
    logic [N_REQ-1:0]    ack_q,      ack_d;
    logic [N_REQ-1:0]    ss_n_q,     ss_n_d;
    logic                busy_q,     busy_d;
    logic                tx_start_q, tx_start_d;
    logic                tx_abort_q, tx_abort_d;

    logic [PTR_W-1:0]    pick_idx;
    logic                pick_vld;

    spi_rr_pick #(
        .N_REQ (N_REQ),
        .PTR_W (PTR_W)
    ) u_pick (
        .req       (req),
        .rr_ptr    (rr_ptr_q),
        .grant_idx (pick_idx),
        .grant_vld (pick_vld)
    );

    // Next-state, counter, grant latches and registered-output values
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        gnt_d      = gnt_q;
        rr_ptr_d   = rr_ptr_q;
        tx_data_d  = tx_data_q;
        mode_d     = mode_q;
        rsp_data_d = rsp_data_q;
        err_pend_d = err_pend_q;
        tx_start_d = 1'b0;
        tx_abort_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (pick_vld) begin
                    state_d   = ST_SETUP;
                    cnt_d     = '0;
                    gnt_d     = pick_idx;
                    tx_data_d = req_data[int'(pick_idx)*DATA_W +: DATA_W];
                    mode_d    = spi_mode_t'(req_mode[int'(pick_idx)*2 +: 2]);
                    rr_ptr_d  = (pick_idx == PTR_W'(N_REQ - 1)) ? '0
                                                                 : pick_idx + PTR_W'(1);
                end
            end
            ST_SETUP: begin
                if (cnt_q == GUARD_LAST) begin
                    state_d    = ST_XFER;
                    cnt_d      = '0;
                    tx_start_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_XFER: begin
                // A completion in the timeout cycle still counts as success
                if (tx_done) begin
                    state_d    = ST_HOLD;
                    cnt_d      = '0;
                    rsp_data_d = tx_rx_data;
                    err_pend_d = 1'b0;
                end else if (cnt_q == TO_LAST) begin
                    state_d    = ST_HOLD;
                    cnt_d      = '0;
                    rsp_data_d = '0;
                    err_pend_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                    // Abort lands in the same cycle the counter reaches the limit
                    if (cnt_q == TO_WARN) begin
                        tx_abort_d = 1'b1;
                    end
                end
            end
            ST_HOLD: begin
                if (cnt_q == GUARD_LAST) begin
                    state_d = ST_GAP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_GAP: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Outputs are functions of the next state so they register cleanly
        ss_n_d = '1;
        ack_d  = '0;
        err_d  = 1'b0;
        if (state_d inside {ST_SETUP, ST_XFER, ST_HOLD}) begin
            ss_n_d[gnt_d] = 1'b0;
        end
        if (state_d == ST_GAP) begin
            ack_d[gnt_d] = 1'b1;
            err_d        = err_pend_d;
        end
        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
        if (rst) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            gnt_q      <= '0;
            rr_ptr_q   <= '0;
            tx_data_q  <= '0;
            mode_q     <= '0;
            rsp_data_q <= '0;
            err_pend_q <= 1'b0;
            err_q      <= 1'b0;
            ack_q      <= '0;
            ss_n_q     <= '1;
            busy_q     <= 1'b0;
            tx_start_q <= 1'b0;
            tx_abort_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            rr_ptr_q   <= rr_ptr_d;
            tx_data_q  <= tx_data_d;
            mode_q     <= mode_d;
            rsp_data_q <= rsp_data_d;
            err_pend_q <= err_pend_d;
            err_q      <= err_d;
            ack_q      <= ack_d;
            ss_n_q     <= ss_n_d;
            busy_q     <= busy_d;
            tx_start_q <= tx_start_d;
            tx_abort_q <= tx_abort_d;
        end
    end

    assign ack      = ack_q;
    assign rsp_data = rsp_data_q;
    assign err      = err_q;
    assign busy     = busy_q;
    assign ss_n     = ss_n_q;
    assign tx_start = tx_start_q;
    assign tx_data  = tx_data_q;
    assign tx_ckp   = mode_q.ckp;
    assign tx_cph   = mode_q.cph;
    assign tx_abort = tx_abort_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter: a default instance for the
// functional sequences and a TIMEOUT_CYC=15 instance for timeout cases.
// Expected acks are queued when requests are driven and popped on ack.
module tb_spi_master_arbiter;

    localparam int N = 4;
    localparam int W = 8;

    typedef struct packed {
        logic [N-1:0] ack;
        logic [W-1:0] data;
        logic         err;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // Default instance
    logic [N-1:0]   req;
    logic [N*W-1:0] req_data;
    logic [2*N-1:0] req_mode;
    logic [N-1:0]   ack, ss_n;
    logic [W-1:0]   rsp_data, tx_data, tx_rx_data;
    logic           err, busy, tx_start, tx_ckp, tx_cph, tx_abort, tx_done;

    // Short-timeout instance
    logic [N-1:0]   t_req;
    logic [N*W-1:0] t_req_data;
    logic [2*N-1:0] t_req_mode;
    logic [N-1:0]   t_ack, t_ss_n;
    logic [W-1:0]   t_rsp_data, t_tx_data, t_tx_rx_data;
    logic           t_err, t_busy, t_tx_start, t_tx_ckp, t_tx_cph, t_tx_abort, t_tx_done;

    spi_master_arbiter #(.N_REQ(N), .DATA_W(W), .GUARD_CYC(2), .TIMEOUT_CYC(1023)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .req_mode(req_mode),
        .ack(ack), .rsp_data(rsp_data), .err(err), .busy(busy), .ss_n(ss_n),
        .tx_start(tx_start), .tx_data(tx_data), .tx_ckp(tx_ckp), .tx_cph(tx_cph),
        .tx_abort(tx_abort), .tx_done(tx_done), .tx_rx_data(tx_rx_data)
    );

    spi_master_arbiter #(.N_REQ(N), .DATA_W(W), .GUARD_CYC(2), .TIMEOUT_CYC(15)) dut_t (
        .clk(clk), .rst(rst), .req(t_req), .req_data(t_req_data), .req_mode(t_req_mode),
        .ack(t_ack), .rsp_data(t_rsp_data), .err(t_err), .busy(t_busy), .ss_n(t_ss_n),
        .tx_start(t_tx_start), .tx_data(t_tx_data), .tx_ckp(t_tx_ckp), .tx_cph(t_tx_cph),
        .tx_abort(t_tx_abort), .tx_done(t_tx_done), .tx_rx_data(t_tx_rx_data)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    exp_t sbt_q[$];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Scoreboard and slave-select checks, sampled away from the active edge
    exp_t         e_a, e_t;
    logic [N-1:0] prev_ss = '1;
    int           hi_run  = 100;

    always @(negedge clk) begin
        if (ack !== '0) begin
            if (sb_q.size() == 0) begin
                chk("ack_unexpected", 32'(ack), 32'h0);
            end else begin
                e_a = sb_q.pop_front();
                chk("ack_idx", 32'(ack), 32'(e_a.ack));
                chk("ack_rsp_data", 32'(rsp_data), 32'(e_a.data));
                chk("ack_err", 32'(err), 32'(e_a.err));
            end
        end
        if (t_ack !== '0) begin
            if (sbt_q.size() == 0) begin
                chk("t_ack_unexpected", 32'(t_ack), 32'h0);
            end else begin
                e_t = sbt_q.pop_front();
                chk("t_ack_idx", 32'(t_ack), 32'(e_t.ack));
                chk("t_ack_rsp_data", 32'(t_rsp_data), 32'(e_t.data));
                chk("t_ack_err", 32'(t_err), 32'(e_t.err));
            end
        end
        if (ss_n !== '1) begin
            if (ss_n !== prev_ss) begin
                chk("ss_onehot", 32'($countones(~ss_n)), 32'd1);
                chk("ss_gap", 32'((prev_ss === '1) && (hi_run >= 2)), 32'd1);
            end
            hi_run = 0;
        end else begin
            hi_run++;
        end
        prev_ss = ss_n;
    end

    task automatic wait_start(input bit on_t, input string tag);
        int n = 0;
        while (n < 64) begin
            @(negedge clk);
            if ((on_t ? t_tx_start : tx_start) === 1'b1) break;
            n++;
        end
        chk(tag, 32'(n < 64), 32'd1);
    endtask

    task automatic wait_ack(input bit on_t, input string tag);
        int n = 0;
        while (n < 64) begin
            @(negedge clk);
            if ((on_t ? t_ack : ack) !== '0) break;
            n++;
        end
        chk(tag, 32'(n < 64), 32'd1);
    endtask

    // Serve one transfer on the default instance, then drop its request
    task automatic serve(input int g, input logic [W-1:0] exp_tx,
                         input logic [1:0] exp_mode, input logic [W-1:0] rx);
        logic [N-1:0] exp_ss;
        exp_ss = ~(4'b0001 << g);
        wait_start(1'b0, "serve_start");
        chk("serve_tx_data", 32'(tx_data), 32'(exp_tx));
        chk("serve_mode", 32'({tx_ckp, tx_cph}), 32'(exp_mode));
        chk("serve_ss_n", 32'(ss_n), 32'(exp_ss));
        @(posedge clk); #1;
        tx_done    = 1'b1;
        tx_rx_data = rx;
        @(posedge clk); #1;
        tx_done    = 1'b0;
        tx_rx_data = '0;
        wait_ack(1'b0, "serve_ack");
        @(posedge clk); #1;
        req[g] = 1'b0;
    endtask

    initial begin
        exp_t e_push;
        rst = 1'b1;
        req = '0; req_data = '0; req_mode = '0; tx_done = 1'b0; tx_rx_data = '0;
        t_req = '0; t_req_data = '0; t_req_mode = '0; t_tx_done = 1'b0; t_tx_rx_data = '0;

        // Reset values
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ss_n", 32'(ss_n), 32'hF);
        chk("rst_ack", 32'(ack), 32'h0);
        chk("rst_err", 32'(err), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_tx_start", 32'(tx_start), 32'h0);
        chk("rst_tx_abort", 32'(tx_abort), 32'h0);
        chk("rst_mode", 32'({tx_ckp, tx_cph}), 32'h0);
        chk("rst_tx_data", 32'(tx_data), 32'h0);
        chk("rst_rsp_data", 32'(rsp_data), 32'h0);
        chk("rst_t_ss_n", 32'(t_ss_n), 32'hF);
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Single request: req[1], 0xA5, mode 01; tx_done in cycle 20 with 0x3C
        req_data[1*W +: W] = 8'hA5;
        req_mode[2*1 +: 2] = 2'b01;
        req = 4'b0010;
        sb_q.push_back(exp_t'{ack: 4'b0010, data: 8'h3C, err: 1'b0});
        for (int c = 0; c <= 23; c++) begin
            tx_done    = (c == 20);
            tx_rx_data = (c == 20) ? 8'h3C : 8'h00;
            @(negedge clk);
            if (c == 0) chk("t1_idle_ss_n", 32'(ss_n), 32'hF);
            if (c >= 1 && c <= 22) chk("t1_ss_n", 32'(ss_n), 32'hD);
            if (c == 1) chk("t1_busy", 32'(busy), 32'h1);
            if (c == 2) chk("t1_no_early_start", 32'(tx_start), 32'h0);
            if (c == 3) begin
                chk("t1_tx_start", 32'(tx_start), 32'h1);
                chk("t1_tx_data", 32'(tx_data), 32'hA5);
                chk("t1_tx_cph", 32'(tx_cph), 32'h1);
                chk("t1_tx_ckp", 32'(tx_ckp), 32'h0);
            end
            if (c == 4) chk("t1_start_once", 32'(tx_start), 32'h0);
            if (c == 22) chk("t1_no_early_ack", 32'(ack), 32'h0);
            if (c == 23) begin
                chk("t1_ack_cycle", 32'(ack), 32'h2);
                chk("t1_gap_ss_n", 32'(ss_n), 32'hF);
            end
            @(posedge clk); #1;
        end
        tx_done = 1'b0;
        req     = '0;

        // tx_done outside XFER is ignored
        tx_done    = 1'b1;
        tx_rx_data = 8'hFF;
        @(posedge clk); #1;
        tx_done    = 1'b0;
        tx_rx_data = '0;
        @(negedge clk);
        chk("idle_done_busy", 32'(busy), 32'h0);
        chk("idle_done_ss_n", 32'(ss_n), 32'hF);
        @(posedge clk); #1;

        // Reset in mid-XFER (grant 2 moves rr_ptr to 3 first)
        req_data[2*W +: W] = 8'h66;
        req_mode[2*2 +: 2] = 2'b11;
        req = 4'b0100;
        wait_start(1'b0, "rst_xfer_start");
        @(posedge clk); #1;
        rst = 1'b1;
        @(negedge clk);
        chk("rst_xfer_pre_busy", 32'(busy), 32'h1);
        @(posedge clk); #1;
        rst = 1'b0;
        req = '0;
        @(negedge clk);
        chk("rst_xfer_ss_n", 32'(ss_n), 32'hF);
        chk("rst_xfer_busy", 32'(busy), 32'h0);
        chk("rst_xfer_ack", 32'(ack), 32'h0);
        repeat (3) begin
            @(posedge clk); #1;
            @(negedge clk);
            chk("rst_xfer_no_ack", 32'(ack), 32'h0);
        end
        @(posedge clk); #1;

        // Contention: all four held; order must start at 0 after reset
        for (int i = 0; i < N; i++) begin
            req_data[i*W +: W] = 8'(8'h10 + i);
            req_mode[2*i +: 2] = 2'(i);
            e_push.ack  = 4'(4'b0001 << i);
            e_push.data = 8'(8'h10 + i) ^ 8'hFF;
            e_push.err  = 1'b0;
            sb_q.push_back(e_push);
        end
        req = 4'b1111;
        for (int k = 0; k < N; k++) begin
            serve(k, 8'(8'h10 + k), 2'(k), 8'(8'h10 + k) ^ 8'hFF);
        end

        // Wrap-around: grant 2 leaves rr_ptr=3, then req=1001 gives 3 then 0
        req_data[2*W +: W] = 8'h44;
        req_mode[2*2 +: 2] = 2'b10;
        sb_q.push_back(exp_t'{ack: 4'b0100, data: 8'hC4, err: 1'b0});
        req = 4'b0100;
        serve(2, 8'h44, 2'b10, 8'hC4);
        req_data[3*W +: W] = 8'h33;
        req_mode[2*3 +: 2] = 2'b11;
        req_data[0*W +: W] = 8'h30;
        req_mode[2*0 +: 2] = 2'b00;
        sb_q.push_back(exp_t'{ack: 4'b1000, data: 8'hB3, err: 1'b0});
        sb_q.push_back(exp_t'{ack: 4'b0001, data: 8'hB0, err: 1'b0});
        req = 4'b1001;
        serve(3, 8'h33, 2'b11, 8'hB3);
        serve(0, 8'h30, 2'b00, 8'hB0);

        // Timeout (TIMEOUT_CYC=15): abort in the 16th XFER cycle, err ack, data 0
        t_req_data[0*W +: W] = 8'h5A;
        t_tx_rx_data = 8'hEE;
        sbt_q.push_back(exp_t'{ack: 4'b0001, data: 8'h00, err: 1'b1});
        t_req = 4'b0001;
        wait_start(1'b1, "to_start");
        chk("to_abort_x1", 32'(t_tx_abort), 32'h0);
        for (int x = 2; x <= 17; x++) begin
            @(posedge clk); #1;
            @(negedge clk);
            if (x == 15) chk("to_abort_x15", 32'(t_tx_abort), 32'h0);
            if (x == 16) begin
                chk("to_abort_x16", 32'(t_tx_abort), 32'h1);
                chk("to_ss_x16", 32'(t_ss_n), 32'hE);
            end
            if (x == 17) begin
                chk("to_abort_x17", 32'(t_tx_abort), 32'h0);
                chk("to_hold_ss", 32'(t_ss_n), 32'hE);
                chk("to_hold_no_ack", 32'(t_ack), 32'h0);
            end
        end
        wait_ack(1'b1, "to_ack");
        @(posedge clk); #1;
        t_req = '0;

        // tx_done coincident with the timeout cycle: success wins
        sbt_q.push_back(exp_t'{ack: 4'b0001, data: 8'h77, err: 1'b0});
        t_req = 4'b0001;
        wait_start(1'b1, "co_start");
        for (int x = 2; x <= 16; x++) begin
            @(posedge clk); #1;
            if (x == 16) begin
                t_tx_done    = 1'b1;
                t_tx_rx_data = 8'h77;
            end
            @(negedge clk);
            if (x == 16) chk("co_abort_x16", 32'(t_tx_abort), 32'h1);
        end
        @(posedge clk); #1;
        t_tx_done    = 1'b0;
        t_tx_rx_data = 8'hEE;
        wait_ack(1'b1, "co_ack");
        @(posedge clk); #1;
        t_req = '0;

        repeat (4) @(posedge clk);
        @(negedge clk);
        chk("sb_drained", 32'(sb_q.size()), 32'h0);
        chk("sbt_drained", 32'(sbt_q.size()), 32'h0);
        chk("final_busy", 32'(busy), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
